// File: rtl/scr_stack_ctrl.sv
// Scratch-RAM controller: direct LD/ST plus a downward-growing byte stack
// with PUSH/POP and two-cycle CALL/RET of a 10-bit return address.
module scr_stack_ctrl (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] OP,
  input  logic       OP_VALID,
  input  logic [7:0] ADDR_IN,
  input  logic [7:0] REG_DATA,
  input  logic [9:0] PC_IN,
  input  logic [7:0] SCR_DATA_OUT,
  output logic [7:0] SCR_ADDR,
  output logic [7:0] SCR_DATA_IN,
  output logic       SCR_WE,
  output logic       BUSY,
  output logic [7:0] RD_DATA,
  output logic       RD_VALID,
  output logic [9:0] RET_PC,
  output logic       RET_VALID,
  output logic [7:0] SP,
  output logic       OVF,
  output logic       UNF
);

  localparam logic [2:0] OP_ST   = 3'b001;
  localparam logic [2:0] OP_LD   = 3'b010;
  localparam logic [2:0] OP_PUSH = 3'b011;
  localparam logic [2:0] OP_POP  = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_RET  = 3'b110;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALL2 = 2'd1;
  localparam logic [1:0] S_RET2  = 2'd2;

  logic [1:0] state;
  logic [7:0] sp;
  logic [8:0] depth;
  logic       ovf;
  logic       unf;
  logic [7:0] call_lo;
  logic [7:0] ret_lo;
  logic [7:0] rd_data_p1;
  logic       vld_p1;
  logic [9:0] ret_pc_p1;
  logic       ret_vld_p1;

  logic       accept;
  logic       push_ok;
  logic       pop_ok;
  logic       call_ok;
  logic       ret_ok;
  logic [7:0] sp_dec;
  logic       we_c;

  assign accept  = OP_VALID && (state == S_IDLE);
  assign push_ok = (depth != 9'd256);
  assign pop_ok  = (depth != 9'd0);
  assign call_ok = (depth <= 9'd254);
  assign ret_ok  = (depth >= 9'd2);
  assign sp_dec  = sp - 8'd1;

  // Scratch RAM port: combinational from current command and state
  always_comb begin
    SCR_ADDR    = sp;
    SCR_DATA_IN = REG_DATA;
    we_c        = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (OP)
            OP_ST: begin
              SCR_ADDR = ADDR_IN;
              we_c     = 1'b1;
            end
            OP_LD:   SCR_ADDR = ADDR_IN;
            OP_PUSH: begin
              SCR_ADDR = sp_dec;
              we_c     = push_ok;
            end
            OP_CALL: begin
              SCR_ADDR    = sp_dec;
              SCR_DATA_IN = {6'b0, PC_IN[9:8]};
              we_c        = call_ok;
            end
            default: SCR_ADDR = sp;
          endcase
        end
      end
      S_CALL2: begin
        SCR_ADDR    = sp_dec;
        SCR_DATA_IN = call_lo;
        we_c        = 1'b1;
      end
      default: SCR_ADDR = sp;
    endcase
  end

  assign SCR_WE = we_c & RST_N;

  // Stage p1: stack state, flags and registered read results
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      sp         <= 8'h00;
      depth      <= 9'd0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      rd_data_p1 <= 8'h00;
      vld_p1     <= 1'b0;
      ret_pc_p1  <= 10'h000;
      ret_vld_p1 <= 1'b0;
    end else begin
      vld_p1     <= 1'b0;
      ret_vld_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (OP)
              OP_LD: begin
                rd_data_p1 <= SCR_DATA_OUT;
                vld_p1     <= 1'b1;
              end
              OP_PUSH: begin
                if (push_ok) begin
                  sp    <= sp_dec;
                  depth <= depth + 9'd1;
                end else begin
                  ovf <= 1'b1;
                end
              end
              OP_POP: begin
                if (pop_ok) begin
                  rd_data_p1 <= SCR_DATA_OUT;
                  vld_p1     <= 1'b1;
                  sp         <= sp + 8'd1;
                  depth      <= depth - 9'd1;
                end else begin
                  unf <= 1'b1;
                end
              end
              OP_CALL: begin
                if (call_ok) begin
                  sp      <= sp_dec;
                  depth   <= depth + 9'd1;
                  call_lo <= PC_IN[7:0];
                  state   <= S_CALL2;
                end else begin
                  ovf <= 1'b1;
                end
              end
              OP_RET: begin
                if (ret_ok) begin
                  ret_lo <= SCR_DATA_OUT;
                  sp     <= sp + 8'd1;
                  depth  <= depth - 9'd1;
                  state  <= S_RET2;
                end else begin
                  unf <= 1'b1;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_CALL2: begin
          sp    <= sp_dec;
          depth <= depth + 9'd1;
          state <= S_IDLE;
        end
        S_RET2: begin
          ret_pc_p1  <= {SCR_DATA_OUT[1:0], ret_lo};
          ret_vld_p1 <= 1'b1;
          sp         <= sp + 8'd1;
          depth      <= depth - 9'd1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY      = (state != S_IDLE);
  assign RD_DATA   = rd_data_p1;
  assign RD_VALID  = vld_p1;
  assign RET_PC    = ret_pc_p1;
  assign RET_VALID = ret_vld_p1;
  assign SP        = sp;
  assign OVF       = ovf;
  assign UNF       = unf;

endmodule
